// File: rtl/dk_motion_if.sv
// Sprite motion bus: VGA raster counters and run enable flow toward the
// controller; sprite placement, pose and barrel request flow back out.
interface dk_motion_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       enable;
  logic [9:0] curr_h;
  logic [9:0] curr_v;
  logic       sprite_selec;
  logic       bounds_draw;
  logic       barrel_throw;
  logic       dir_left;

  modport master (
    output hcount, vcount, enable,
    input  curr_h, curr_v, sprite_selec, bounds_draw, barrel_throw, dir_left
  );

  modport slave (
    input  hcount, vcount, enable,
    output curr_h, curr_v, sprite_selec, bounds_draw, barrel_throw, dir_left
  );
endinterface

// File: rtl/dk_motion.sv
// Donkey Kong sprite motion controller. Once per video frame (on the raster
// tick) it walks the sprite right along its girder, pauses in a throw pose at
// the right end while requesting one barrel, then walks back left. All outputs
// are registered and only change on the clock after the tick, so the sprite
// never tears mid-frame.
module dk_motion #(
  parameter int X_MIN        = 64,
  parameter int X_MAX        = 512,
  parameter int Y_POS        = 40,
  parameter int STEP         = 2,
  parameter int ANIM_FRAMES  = 8,
  parameter int THROW_FRAMES = 30,
  parameter int TICK_H       = 0,
  parameter int TICK_V       = 480
) (
  input  logic       clk,
  input  logic       rst,
  dk_motion_if.slave bus
);

  // Position math is done one bit wider than the screen coordinate so the
  // right-edge comparison can never wrap.
  localparam logic [10:0] X_MIN_W    = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W    = 11'(X_MAX);
  localparam logic [10:0] STEP_W     = 11'(STEP);
  localparam logic [9:0]  X_MIN_H    = 10'(X_MIN);
  localparam logic [9:0]  X_MAX_H    = 10'(X_MAX);
  localparam logic [9:0]  STEP_H     = 10'(STEP);
  localparam logic [9:0]  Y_POS_H    = 10'(Y_POS);
  localparam logic [9:0]  TICK_H_W   = 10'(TICK_H);
  localparam logic [9:0]  TICK_V_W   = 10'(TICK_V);
  localparam logic [7:0]  ANIM_LAST  = 8'(ANIM_FRAMES - 1);
  localparam logic [7:0]  THROW_LAST = 8'(THROW_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK_R = 2'd1,
    THROW  = 2'd2,
    WALK_L = 2'd3
  } state_t;

  // One animation step: count walking frames and flip the pose each time the
  // count wraps. Result is {sprite_selec, anim_cnt}.
  function automatic logic [8:0] anim_step(input logic [7:0] cnt, input logic sel);
    logic [8:0] res;
    if (cnt == ANIM_LAST) begin
      res = {~sel, 8'd0};
    end else begin
      res = {sel, cnt + 8'd1};
    end
    return res;
  endfunction

  state_t      state_r;
  logic [9:0]  curr_h_r;
  logic [9:0]  curr_v_r;
  logic        sprite_selec_r;
  logic        bounds_draw_r;
  logic        barrel_throw_r;
  logic        dir_left_r;
  logic [7:0]  anim_cnt_r;
  logic [7:0]  throw_cnt_r;

  logic        tick_s;
  logic [10:0] h_ext_s;
  logic [10:0] h_inc_s;
  logic        at_right_s;
  logic        at_left_s;
  logic [8:0]  anim_cont_s;
  logic [8:0]  anim_entry_s;

  // Exactly one raster position per frame is the tick.
  assign tick_s       = (bus.hcount == TICK_H_W) && (bus.vcount == TICK_V_W);
  assign h_ext_s      = {1'b0, curr_h_r};
  assign h_inc_s      = h_ext_s + STEP_W;
  assign at_right_s   = (h_inc_s >= X_MAX_W);
  assign at_left_s    = (h_ext_s <= (X_MIN_W + STEP_W));
  // Continuing a walk advances from the current count; entering a walk
  // restarts from count 0 in the stand pose, and the entry tick itself counts.
  assign anim_cont_s  = anim_step(anim_cnt_r, sprite_selec_r);
  assign anim_entry_s = anim_step(8'd0, 1'b0);

  assign bus.curr_h       = curr_h_r;
  assign bus.curr_v       = curr_v_r;
  assign bus.sprite_selec = sprite_selec_r;
  assign bus.bounds_draw  = bounds_draw_r;
  assign bus.barrel_throw = barrel_throw_r;
  assign bus.dir_left     = dir_left_r;

  // Motion FSM: all state, position and pose updates happen on the frame tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      curr_h_r       <= X_MIN_H;
      curr_v_r       <= Y_POS_H;
      sprite_selec_r <= 1'b0;
      bounds_draw_r  <= 1'b0;
      barrel_throw_r <= 1'b0;
      dir_left_r     <= 1'b0;
      anim_cnt_r     <= 8'd0;
      throw_cnt_r    <= 8'd0;
    end else begin
      // The barrel request is a single-clock pulse.
      barrel_throw_r <= 1'b0;
      if (tick_s) begin
        if (!bus.enable) begin
          // Park in place; any throw in progress is dropped without a pulse.
          state_r        <= IDLE;
          sprite_selec_r <= 1'b0;
          bounds_draw_r  <= 1'b0;
          dir_left_r     <= 1'b0;
        end else begin
          bounds_draw_r <= 1'b1;
          case (state_r)
            IDLE, WALK_R: begin
              dir_left_r <= 1'b0;
              if (at_right_s) begin
                curr_h_r       <= X_MAX_H;
                state_r        <= THROW;
                throw_cnt_r    <= 8'd0;
                sprite_selec_r <= 1'b1;
                barrel_throw_r <= 1'b1;
              end else begin
                curr_h_r <= h_inc_s[9:0];
                state_r  <= WALK_R;
                if (state_r == IDLE) begin
                  {sprite_selec_r, anim_cnt_r} <= anim_entry_s;
                end else begin
                  {sprite_selec_r, anim_cnt_r} <= anim_cont_s;
                end
              end
            end
            THROW: begin
              if (throw_cnt_r == THROW_LAST) begin
                state_r                      <= WALK_L;
                dir_left_r                   <= 1'b1;
                {sprite_selec_r, anim_cnt_r} <= anim_entry_s;
              end else begin
                throw_cnt_r    <= throw_cnt_r + 8'd1;
                sprite_selec_r <= 1'b1;
              end
            end
            WALK_L: begin
              if (at_left_s) begin
                curr_h_r                     <= X_MIN_H;
                state_r                      <= WALK_R;
                dir_left_r                   <= 1'b0;
                {sprite_selec_r, anim_cnt_r} <= anim_entry_s;
              end else begin
                curr_h_r                     <= curr_h_r - STEP_H;
                dir_left_r                   <= 1'b1;
                {sprite_selec_r, anim_cnt_r} <= anim_cont_s;
              end
            end
            default: begin
              state_r        <= IDLE;
              sprite_selec_r <= 1'b0;
              bounds_draw_r  <= 1'b0;
              dir_left_r     <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dk_motion.sv
// Self-checking bench for dk_motion. Raster counters are driven directly so a
// "frame" is a few clocks; a behavioural model tracks the sprite in plain
// integers (position, walking-tick count, throw-tick count).
module tb_dk_motion;
  localparam int X_MIN        = 64;
  localparam int X_MAX        = 512;
  localparam int Y_POS        = 40;
  localparam int STEP         = 2;
  localparam int ANIM_FRAMES  = 8;
  localparam int THROW_FRAMES = 30;

  localparam int PARK     = 0;
  localparam int RIGHT    = 1;
  localparam int THROWING = 2;
  localparam int LEFT     = 3;

  logic clk = 1'b0;
  logic rst;
  dk_motion_if bus();

  dk_motion dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  int m_mode;
  int m_h;
  int m_walk;   // walking ticks since entering the current walk
  int m_throw;  // ticks spent in the throw pose
  bit exp_pulse;

  task automatic model_reset();
    m_mode    = PARK;
    m_h       = X_MIN;
    m_walk    = 0;
    m_throw   = 0;
    exp_pulse = 1'b0;
  endtask

  task automatic model_tick();
    if (m_mode != PARK && !bus.enable) begin
      m_mode = PARK;
    end else if (m_mode == THROWING) begin
      m_throw++;
      if (m_throw == THROW_FRAMES) begin
        m_mode = LEFT;
        m_walk = 1;
      end
    end else if (m_mode == LEFT) begin
      m_walk++;
      if (m_h <= X_MIN + STEP) begin
        m_h    = X_MIN;
        m_mode = RIGHT;
        m_walk = 1;
      end else begin
        m_h -= STEP;
      end
    end else if (bus.enable) begin
      if (m_h + STEP >= X_MAX) begin
        m_h       = X_MAX;
        m_mode    = THROWING;
        m_throw   = 0;
        exp_pulse = 1'b1;
      end else begin
        m_walk = (m_mode == PARK) ? 1 : m_walk + 1;
        m_h   += STEP;
        m_mode = RIGHT;
      end
    end
  endtask

  // {curr_h, curr_v, sprite_selec, bounds_draw, barrel_throw, dir_left}
  function automatic logic [23:0] model_vec();
    logic sel;
    if (m_mode == THROWING) sel = 1'b1;
    else if (m_mode == PARK) sel = 1'b0;
    else sel = 1'(((m_walk / ANIM_FRAMES) % 2));
    return {10'(m_h), 10'(Y_POS), sel, (m_mode != PARK), exp_pulse, (m_mode == LEFT)};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {bus.curr_h, bus.curr_v, bus.sprite_selec, bus.bounds_draw, bus.barrel_throw, bus.dir_left};
  endfunction

  // One clock: drive either the tick position or a random non-tick position
  // (often a near miss on one coordinate), then advance the model.
  task automatic step(input bit t);
    int k;
    logic [9:0] h;
    logic [9:0] v;
    if (t) begin
      h = 10'd0;
      v = 10'd480;
    end else begin
      k = $urandom_range(2, 0);
      h = 10'($urandom_range(799, 0));
      v = 10'($urandom_range(524, 0));
      if (k == 0) h = 10'd0;
      if (k == 1) v = 10'd480;
      if (h == 10'd0 && v == 10'd480) begin
        if (k == 0) v = 10'd481;
        else h = 10'd1;
      end
    end
    bus.hcount = h;
    bus.vcount = v;
    @(posedge clk);
    #1;
    exp_pulse = 1'b0;
    if (t && !rst) model_tick();
  endtask

  task automatic frame();
    int gap = $urandom_range(3, 0);
    for (int i = 0; i < gap; i++) step(1'b0);
    step(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== {10'd64, 10'd40, 4'b0000}) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", dut_vec(), {10'd64, 10'd40, 4'b0000});
    end
    rst = 1'b0;
    frame();
    checks++;
    if (dut_vec() !== {10'd64, 10'd40, 4'b0000}) begin
      failures++;
      $display("FAIL idle_disabled_tick got=%h exp=%h", dut_vec(), {10'd64, 10'd40, 4'b0000});
    end
  endtask

  task automatic test_first_frame();
    bus.enable = 1'b1;
    repeat (3) step(1'b0);
    step(1'b1);
    checks++;
    if (dut_vec() !== {10'd66, 10'd40, 4'b0100}) begin
      failures++;
      $display("FAIL first_frame got=%h exp=%h", dut_vec(), {10'd66, 10'd40, 4'b0100});
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      checks++;
      if (dut_vec() !== {10'd66, 10'd40, 4'b0100}) begin
        failures++;
        $display("FAIL hold_within_frame cycle=%0d got=%h exp=%h", i, dut_vec(), {10'd66, 10'd40, 4'b0100});
      end
    end
  endtask

  task automatic test_walk_anim();
    for (int n = 2; n <= 16; n++) begin
      frame();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL walk_anim tick=%0d got=%h exp=%h", n, dut_vec(), model_vec());
      end
      if (n == 8) begin
        checks++;
        if (dut_vec() !== {10'd80, 10'd40, 4'b1100}) begin
          failures++;
          $display("FAIL anim_toggle_8 got=%h exp=%h", dut_vec(), {10'd80, 10'd40, 4'b1100});
        end
      end
      if (n == 16) begin
        checks++;
        if (dut_vec() !== {10'd96, 10'd40, 4'b0100}) begin
          failures++;
          $display("FAIL anim_toggle_16 got=%h exp=%h", dut_vec(), {10'd96, 10'd40, 4'b0100});
        end
      end
    end
  endtask

  task automatic test_throw();
    int g = 0;
    while (m_h != 510 && g < 400) begin
      frame();
      g++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL walk_right tick=%0d got=%h exp=%h", g, dut_vec(), model_vec());
      end
    end
    checks++;
    if (g >= 400) begin
      failures++;
      $display("FAIL reach_510 timeout got=%0d exp=510", m_h);
    end
    frame();
    checks++;
    if (dut_vec() !== {10'd512, 10'd40, 4'b1110}) begin
      failures++;
      $display("FAIL throw_entry got=%h exp=%h", dut_vec(), {10'd512, 10'd40, 4'b1110});
    end
    step(1'b0);
    checks++;
    if (dut_vec() !== {10'd512, 10'd40, 4'b1100}) begin
      failures++;
      $display("FAIL pulse_one_clk got=%h exp=%h", dut_vec(), {10'd512, 10'd40, 4'b1100});
    end
    for (int i = 1; i < THROW_FRAMES; i++) begin
      frame();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL throw_pose frame=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    frame();
    checks++;
    if (dut_vec() !== {10'd512, 10'd40, 4'b0101}) begin
      failures++;
      $display("FAIL throw_exit got=%h exp=%h", dut_vec(), {10'd512, 10'd40, 4'b0101});
    end
    frame();
    checks++;
    if (dut_vec() !== {10'd510, 10'd40, 4'b0101}) begin
      failures++;
      $display("FAIL first_left_step got=%h exp=%h", dut_vec(), {10'd510, 10'd40, 4'b0101});
    end
  endtask

  task automatic test_walk_left();
    int g = 0;
    while (m_h != 66 && g < 400) begin
      frame();
      g++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL walk_left tick=%0d got=%h exp=%h", g, dut_vec(), model_vec());
      end
    end
    checks++;
    if (g >= 400) begin
      failures++;
      $display("FAIL reach_66 timeout got=%0d exp=66", m_h);
    end
    frame();
    checks++;
    if (dut_vec() !== {10'd64, 10'd40, 4'b0100}) begin
      failures++;
      $display("FAIL left_clamp got=%h exp=%h", dut_vec(), {10'd64, 10'd40, 4'b0100});
    end
    frame();
    checks++;
    if (dut_vec() !== {10'd66, 10'd40, 4'b0100}) begin
      failures++;
      $display("FAIL left_turnaround got=%h exp=%h", dut_vec(), {10'd66, 10'd40, 4'b0100});
    end
  endtask

  task automatic test_enable_drop();
    int g = 0;
    while (!(m_mode == THROWING && m_throw == 10) && g < 600) begin
      frame();
      g++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL to_mid_throw tick=%0d got=%h exp=%h", g, dut_vec(), model_vec());
      end
    end
    bus.enable = 1'b0;
    frame();
    checks++;
    if (dut_vec() !== {10'd512, 10'd40, 4'b0000}) begin
      failures++;
      $display("FAIL drop_in_throw got=%h exp=%h", dut_vec(), {10'd512, 10'd40, 4'b0000});
    end
    for (int i = 0; i < 3; i++) begin
      frame();
      checks++;
      if (dut_vec() !== {10'd512, 10'd40, 4'b0000}) begin
        failures++;
        $display("FAIL parked_no_pulse frame=%0d got=%h exp=%h", i, dut_vec(), {10'd512, 10'd40, 4'b0000});
      end
    end
    bus.enable = 1'b1;
    frame();
    checks++;
    if (dut_vec() !== {10'd512, 10'd40, 4'b1110}) begin
      failures++;
      $display("FAIL reenable_clamp got=%h exp=%h", dut_vec(), {10'd512, 10'd40, 4'b1110});
    end
    step(1'b0);
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++;
      $display("FAIL reenable_pulse_end got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_same_tick();
    int g = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bus.enable = 1'b1;
    while (m_h != 510 && g < 400) begin
      frame();
      g++;
    end
    checks++;
    if (dut_vec() !== {10'd510, 10'd40, model_vec()[3:0]}) begin
      failures++;
      $display("FAIL same_tick_setup got=%h exp=%h", dut_vec(), model_vec());
    end
    bus.enable = 1'b0;
    step(1'b1);
    checks++;
    if (dut_vec() !== {10'd510, 10'd40, 4'b0000}) begin
      failures++;
      $display("FAIL idle_wins_at_max got=%h exp=%h", dut_vec(), {10'd510, 10'd40, 4'b0000});
    end
  endtask

  task automatic test_async_reset();
    int g = 0;
    bus.enable = 1'b1;
    while (m_h != 300 && g < 400) begin
      frame();
      g++;
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++;
      $display("FAIL pre_reset_300 got=%h exp=%h", dut_vec(), model_vec());
    end
    step(1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== {10'd64, 10'd40, 4'b0000}) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", dut_vec(), {10'd64, 10'd40, 4'b0000});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    frame();
    checks++;
    if (dut_vec() !== {10'd66, 10'd40, 4'b0100}) begin
      failures++;
      $display("FAIL restart_after_reset got=%h exp=%h", dut_vec(), {10'd66, 10'd40, 4'b0100});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (!bus.enable && $urandom_range(7, 0) == 0) bus.enable = 1'b1;
      else if (bus.enable && $urandom_range(99, 0) == 0) bus.enable = 1'b0;
      step($urandom_range(1, 0) == 1);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL random cycle=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  // Main sequence
  initial begin
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.hcount = 10'd5;
    bus.vcount = 10'd5;
    model_reset();
    test_reset();
    test_first_frame();
    test_walk_anim();
    test_throw();
    test_walk_left();
    test_enable_drop();
    test_same_tick();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Run-time bound
  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
